// File: rtl/decoder_pkg.sv
// Shared types and decode helpers for decoder_pipe: lane-index convention,
// decode-mode enum, and one-hot / thermometer expansion of a binary code.
package decoder_pkg;

    localparam int MAX_IN_W  = 6;
    localparam int MAX_OUT_W = 1 << MAX_IN_W;

    // Code 0 selects the lane MSB; thermometer fills grow from the MSB down.
    localparam bit LANE_MSB_FIRST = 1'b1;

    typedef enum logic {
        DEC_ONEHOT = 1'b0,
        DEC_THERMO = 1'b1
    } dec_mode_e;

    function automatic logic [MAX_OUT_W-1:0] onehot_dec(
        input logic [MAX_IN_W-1:0] code,
        input int                  in_w
    );
        logic [MAX_OUT_W-1:0] res;
        int out_w;
        int pos;
        out_w = 1 << in_w;
        pos   = LANE_MSB_FIRST ? (out_w - 1 - int'(code)) : int'(code);
        res   = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            res[i] = (i == pos);
        end
        return res;
    endfunction

    function automatic logic [MAX_OUT_W-1:0] thermo_dec(
        input logic [MAX_IN_W-1:0] code,
        input int                  in_w
    );
        logic [MAX_OUT_W-1:0] res;
        int out_w;
        int pos;
        out_w = 1 << in_w;
        pos   = LANE_MSB_FIRST ? (out_w - 1 - int'(code)) : int'(code);
        res   = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            res[i] = LANE_MSB_FIRST ? ((i >= pos) && (i < out_w)) : (i <= pos);
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_pipe_stage.sv
// Generic single-entry valid/ready register slice; accepts a new word when
// empty or when its current word leaves in the same cycle.
module decoder_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            // NOTE: the payload is a single word, not a memory array, so it is
            // reset too and reads as zero after reset.
            data_q  <= '0;
        end else begin
            if (ready_o) begin
                valid_q <= valid_i;
            end
            if (valid_i && ready_o) begin
                data_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Two-stage pipelined N-to-2^N decoder with valid/ready flow control, per-channel
// masking and a delivered-beat counter. Optional DECODER_PIPE_THERMO_EN adds in_thermo.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter  int IN_W  = 4,
    parameter  int CH    = 1,
    parameter  int CNT_W = 8,
    localparam int OUT_W = 1 << IN_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*IN_W-1:0]  in_code,
    input  logic [CH-1:0]       in_mask,
`ifdef DECODER_PIPE_THERMO_EN
    input  logic                in_thermo,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH*OUT_W-1:0] out_lane,
    output logic [CNT_W-1:0]    beat_cnt
);

`ifdef DECODER_PIPE_THERMO_EN
    localparam int S1_W = CH*IN_W + CH + 1;
`else
    localparam int S1_W = CH*IN_W + CH;
`endif

    logic [S1_W-1:0]     s1_d;
    logic [S1_W-1:0]     s1_q;
    logic                s1_ready;
    logic                s1_valid;
    logic                s2_ready;
    logic [CH*IN_W-1:0]  s1_code;
    logic [CH-1:0]       s1_mask;
    dec_mode_e           s1_mode;
    logic [CH*OUT_W-1:0] lane_d;
    logic [CNT_W-1:0]    beat_cnt_d;
    logic [CNT_W-1:0]    beat_cnt_q;

`ifdef DECODER_PIPE_THERMO_EN
    assign s1_d    = {in_thermo, in_mask, in_code};
    assign s1_mode = s1_q[S1_W-1] ? DEC_THERMO : DEC_ONEHOT;
`else
    assign s1_d    = {in_mask, in_code};
    assign s1_mode = DEC_ONEHOT;
`endif

    assign s1_code = s1_q[CH*IN_W-1:0];
    assign s1_mask = s1_q[CH*IN_W +: CH];

    // Gating with reset_n keeps upstream from seeing a ready slot during reset.
    assign in_ready = reset_n && s1_ready;

    decoder_pipe_stage #(.W(S1_W)) u_code_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (in_valid),
        .ready_o (s1_ready),
        .data_i  (s1_d),
        .valid_o (s1_valid),
        .ready_i (s2_ready),
        .data_o  (s1_q)
    );

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [MAX_IN_W-1:0] code_c;
        logic [OUT_W-1:0]    dec_c;

        assign code_c = MAX_IN_W'(s1_code[c*IN_W +: IN_W]);
        assign dec_c  = (s1_mode == DEC_THERMO) ? OUT_W'(thermo_dec(code_c, IN_W))
                                                : OUT_W'(onehot_dec(code_c, IN_W));
        assign lane_d[c*OUT_W +: OUT_W] = s1_mask[c] ? '0 : dec_c;
    end

    decoder_pipe_stage #(.W(CH*OUT_W)) u_lane_stage (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (s1_valid),
        .ready_o (s2_ready),
        .data_i  (lane_d),
        .valid_o (out_valid),
        .ready_i (out_ready),
        .data_o  (out_lane)
    );

    assign beat_cnt_d = (out_valid && out_ready) ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
    assign beat_cnt   = beat_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
// Self-checking bench for decoder_pipe (IN_W=4, CH=4, CNT_W=3) with a queue-based
// reference model; thermometer checks run when DECODER_PIPE_THERMO_EN is defined.
module tb_decoder_pipe;

    localparam int IN_W  = 4;
    localparam int CH    = 4;
    localparam int CNT_W = 3;
    localparam int OUT_W = 16;

    logic                clk       = 1'b0;
    logic                reset_n   = 1'b0;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic [CH*IN_W-1:0]  in_code   = '0;
    logic [CH-1:0]       in_mask   = '0;
    logic                in_ready;
    logic                out_valid;
    logic [CH*OUT_W-1:0] out_lane;
    logic [CNT_W-1:0]    beat_cnt;
    logic                thermo_eff;

`ifdef DECODER_PIPE_THERMO_EN
    logic in_thermo = 1'b0;
    assign thermo_eff = in_thermo;
`else
    assign thermo_eff = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    int acc      = 0;
    bit exp_valid;

    typedef struct {
        logic [63:0] lanes;
        int          stamp;
    } beat_t;

    beat_t       model_q[$];
    logic [63:0] delivered[$];

    decoder_pipe #(.IN_W(IN_W), .CH(CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_mask   (in_mask),
`ifdef DECODER_PIPE_THERMO_EN
        .in_thermo (in_thermo),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lane  (out_lane),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lane contents computed from the decode rules with plain arithmetic.
    function automatic logic [63:0] expect_lanes(input logic [15:0] code, input logic [3:0] mask,
                                                 input logic thermo);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int k;
            k = int'(code[c*IN_W +: IN_W]);
            if (mask[c])     r[c*OUT_W +: OUT_W] = 16'h0000;
            else if (thermo) r[c*OUT_W +: OUT_W] = 16'(((1 << (k + 1)) - 1) << (15 - k));
            else             r[c*OUT_W +: OUT_W] = 16'(1 << (15 - k));
        end
        return r;
    endfunction

    // Reference model and per-cycle compare, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            model_q.delete();
            exp_cnt = 0;
        end else begin
            exp_valid = (model_q.size() >= 2) ||
                        (model_q.size() == 1 && model_q[0].stamp < cyc - 1);
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            if (out_valid && model_q.size() > 0) check("out_lane", out_lane, model_q[0].lanes);
            check("in_ready", 64'(in_ready), 64'((model_q.size() < 2) || out_ready));
            check("beat_cnt", 64'(beat_cnt), 64'(exp_cnt % (1 << CNT_W)));
            if (out_valid && out_ready) begin
                delivered.push_back(out_lane);
                if (model_q.size() > 0) void'(model_q.pop_front());
                exp_cnt++;
            end
            if (in_valid && in_ready)
                model_q.push_back('{expect_lanes(in_code, in_mask, thermo_eff), cyc});
        end
        cyc++;
    end

    task automatic send(input logic [15:0] code, input logic [3:0] mask);
        int budget;
        budget   = 50;
        in_valid = 1'b1;
        in_code  = code;
        in_mask  = mask;
        #1;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("send_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_delivered(input int n);
        int budget;
        budget = 100;
        while (delivered.size() < n && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check("deliver_count", 64'(delivered.size()), 64'(n));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        check("rst_out_lane", out_lane, 64'd0);
        reset_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Codes 0..15 back-to-back on channel 0, other channels masked
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) send(16'(k), 4'b1110);
        in_valid = 1'b0;
        wait_delivered(16);
        for (int k = 0; k < 16; k++)
            if (k < delivered.size()) check($sformatf("sweep_%0d", k), delivered[k], 64'h8000 >> k);
        check("sweep_beat_cnt", 64'(beat_cnt), 64'd0);
        delivered.delete();

        // Four channels, channel 2 masked
        send(16'hF073, 4'b0100);
        in_valid = 1'b0;
        wait_delivered(1);
        if (delivered.size() > 0) check("ch4_pattern", delivered[0], 64'h0001_0000_0100_1000);
        delivered.delete();

        // Backpressure: out_ready low for 5 cycles with in_valid high
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = 16'(acc + 1);
            in_mask  = 4'b1110;
            #1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_accepted", 64'(acc), 64'd2);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = acc; i < 6; i++) send(16'(i + 1), 4'b1110);
        in_valid = 1'b0;
        wait_delivered(6);
        for (int i = 0; i < 6; i++)
            if (i < delivered.size()) check($sformatf("bp_order_%0d", i), delivered[i], 64'h8000 >> (i + 1));
        delivered.delete();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = 16'($urandom());
            in_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef DECODER_PIPE_THERMO_EN
            in_thermo = 1'($urandom());
`endif
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef DECODER_PIPE_THERMO_EN
        in_thermo = 1'b0;
`endif
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", 64'(out_valid), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 16'h000D;
        in_mask   = 4'b1110;
        repeat (3) @(posedge clk);
        #1;
        check("full_before_rst", 64'(in_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        delivered.delete();
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_beat_cnt", 64'(beat_cnt), 64'd0);
        @(posedge clk); #1;

        // Counter wrap with CNT_W=3 over 9 beats; stale code 13 must not appear
        for (int k = 0; k < 9; k++) send(16'(k), 4'b1110);
        in_valid = 1'b0;
        wait_delivered(9);
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_beats", 64'(delivered.size()), 64'd9);
        for (int k = 0; k < 9; k++)
            if (k < delivered.size()) check($sformatf("wrap_beat_%0d", k), delivered[k], 64'h8000 >> k);
        check("wrap_beat_cnt", 64'(beat_cnt), 64'd1);
        delivered.delete();

`ifdef DECODER_PIPE_THERMO_EN
        in_thermo = 1'b1;
        send(16'h0002, 4'b1110);
        in_thermo = 1'b0;
        send(16'h0002, 4'b1110);
        in_thermo = 1'b1;
        send(16'h000F, 4'b1100);
        in_valid = 1'b0;
        wait_delivered(3);
        if (delivered.size() > 2) begin
            check("thermo_code2", delivered[0], 64'h0000_0000_0000_E000);
            check("onehot_code2", delivered[1], 64'h0000_0000_0000_2000);
            check("thermo_code15", delivered[2], 64'h0000_0000_8000_FFFF);
        end
        in_thermo = 1'b0;
        delivered.delete();
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
